// File: rtl/pfloat_pkg.sv
// Shared types and constants for the fixed-to-float conversion path.
package pfloat_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    ROUND,
    PACK,
    DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

endpackage

// File: rtl/float_round_pack.sv
// Combinational rounding and packing of a normalized magnitude into a
// single-precision word. ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the mantissa is truncated toward zero.
module float_round_pack
  import pfloat_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int SH_W = $clog2(W)
) (
  input  logic [W-1:0]    mag_i,
  input  logic            sign_i,
  input  logic [SH_W-1:0] shcnt_i,
  output float_t          res_o
);

  // Exponent of a value whose leading one already sits in the MSB.
  localparam logic [8:0] EXP_BASE = 9'(BIAS + W - 1 - FRAC);

  logic [MAN_W-1:0] man_t;
  logic             inc;
  logic [MAN_W:0]   man_sum;
  logic [8:0]       exp_n;
  logic [8:0]       exp_r;
  logic             unused_lead;
  logic             unused_exp_msb;

  // The leading one is implicit in the IEEE format.
  assign unused_lead = mag_i[W-1];
  assign man_t       = mag_i[W-2 -: MAN_W];

`ifdef ROUND_NEAREST_EN
  logic guard;
  logic sticky;

  assign guard = mag_i[W-25];
  if (W > 25) begin : g_sticky
    assign sticky = |mag_i[W-26:0];
  end else begin : g_no_sticky
    assign sticky = 1'b0;
  end
  assign inc = guard & (sticky | man_t[0]);
`else
  logic unused_low;

  assign unused_low = ^mag_i[W-25:0];
  assign inc        = 1'b0;
`endif

  // A carry out of the mantissa leaves man_sum[22:0] at zero and bumps the exponent.
  assign man_sum        = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
  assign exp_n          = EXP_BASE - {{(9-SH_W){1'b0}}, shcnt_i};
  assign exp_r          = exp_n + {8'd0, man_sum[MAN_W]};
  assign unused_exp_msb = exp_r[8];

  assign res_o = '{sign: sign_i, exp: exp_r[EXP_W-1:0], man: man_sum[MAN_W-1:0]};

endmodule

// File: rtl/pfixed_to_pfloat.sv
// Iterative signed fixed-point to IEEE-754 single-precision converter.
// One normalization shift per cycle; Begin/ACK level handshake.
// Optional macro ROUND_NEAREST_EN: round-to-nearest-even instead of truncation.
module pfixed_to_pfloat
  import pfloat_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RST_FSM_FX,
  input  logic                Begin_FSM_FX,
  input  logic signed [W-1:0] FX,
  output logic                ACK_FX,
  output logic [31:0]         RESULT
);

  localparam int SH_W = $clog2(W);

  state_t          state_q, state_d;
  logic            sign_q,  sign_d;
  logic [W-1:0]    mag_q,   mag_d;
  logic [SH_W-1:0] shcnt_q, shcnt_d;
  logic            zero_q,  zero_d;
  float_t          fp_q,    fp_d;
  float_t          res_q,   res_d;
  float_t          fp_w;

  float_round_pack #(
    .W    (W),
    .FRAC (FRAC),
    .SH_W (SH_W)
  ) u_round_pack (
    .mag_i   (mag_q),
    .sign_i  (sign_q),
    .shcnt_i (shcnt_q),
    .res_o   (fp_w)
  );

  // Next-state and datapath update for each FSM state; the FSM reset only redirects control.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    shcnt_d = shcnt_q;
    zero_d  = zero_q;
    fp_d    = fp_q;
    res_d   = res_q;
    if (RST_FSM_FX) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Begin_FSM_FX) state_d = LOAD;
        end
        LOAD: begin
          // Negating the most negative value wraps to 2^(W-1), which is the correct magnitude.
          sign_d  = FX[W-1];
          mag_d   = FX[W-1] ? $unsigned(-FX) : $unsigned(FX);
          shcnt_d = '0;
          zero_d  = (FX == '0);
          state_d = (FX == '0) ? PACK : NORM;
        end
        NORM: begin
          if (mag_q[W-1]) begin
            state_d = ROUND;
          end else begin
            mag_d   = mag_q << 1;
            shcnt_d = shcnt_q + 1'b1;
          end
        end
        ROUND: begin
          fp_d    = fp_w;
          state_d = PACK;
        end
        PACK: begin
          // Zero never reaches ROUND, so force +0 instead of using fp_q.
          res_d   = zero_q ? float_t'('0) : fp_q;
          state_d = DONE;
        end
        DONE: begin
          if (!Begin_FSM_FX) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      shcnt_q <= '0;
      zero_q  <= 1'b0;
      fp_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      shcnt_q <= shcnt_d;
      zero_q  <= zero_d;
      fp_q    <= fp_d;
      res_q   <= res_d;
    end
  end

  assign ACK_FX = (state_q == DONE);
  assign RESULT = res_q;

endmodule

// File: tb/tb_pfixed_to_pfloat.sv
// Self-checking bench for pfixed_to_pfloat (W=32, FRAC=16).
// Reference model honours ROUND_NEAREST_EN the same way the design does.
module tb_pfixed_to_pfloat;

  localparam int W    = 32;
  localparam int FRAC = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RST_FSM_FX;
  logic        Begin_FSM_FX;
  logic [31:0] FX;
  logic        ACK_FX;
  logic [31:0] RESULT;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_exp = 32'h0;

  always #5 CLK = ~CLK;

  pfixed_to_pfloat #(
    .W    (W),
    .FRAC (FRAC)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .RST_FSM_FX   (RST_FSM_FX),
    .Begin_FSM_FX (Begin_FSM_FX),
    .FX           (FX),
    .ACK_FX       (ACK_FX),
    .RESULT       (RESULT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level reference: |FX| / 2^FRAC rounded to 24 significant bits.
  function automatic void model(input logic [31:0] fx, output logic [31:0] res, output int lat);
    longint unsigned m;
    longint unsigned mf;
    int              p;
    int              sh;
    int              e;
    logic            s;
    res = 32'h0;
    lat = 2;
    if (fx == 32'd0) return;
    s = fx[31];
    m = s ? (64'h1_0000_0000 - {32'd0, fx}) : {32'd0, fx};
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p - FRAC;
    if (p >= 23) begin
      sh = p - 23;
      mf = m >> sh;
`ifdef ROUND_NEAREST_EN
      if (sh > 0) begin
        longint unsigned rem;
        longint unsigned half;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mf[0])) mf = mf + 64'd1;
      end
`endif
    end else begin
      mf = m << (23 - p);
    end
    if (mf == (64'd1 << 24)) begin
      mf = mf >> 1;
      e  = e + 1;
    end
    res = {s, 8'(e), mf[22:0]};
    lat = 31 - p + 4;
  endfunction

  task automatic convert(input logic [31:0] fx, input string tag);
    logic [31:0] er;
    int          el;
    int          n;
    model(fx, er, el);
    @(negedge CLK);
    FX           = fx;
    Begin_FSM_FX = 1'b1;
    @(posedge CLK);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (ACK_FX !== 1'b1 && n < 100);
    check({tag, " latency"}, 32'(n), 32'(el));
    check({tag, " result"}, RESULT, er);
    @(posedge CLK);
    #1;
    check({tag, " ack_hold"}, {31'd0, ACK_FX}, 32'd1);
    check({tag, " result_hold"}, RESULT, er);
    @(negedge CLK);
    Begin_FSM_FX = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, " ack_drop"}, {31'd0, ACK_FX}, 32'd0);
    last_exp = er;
  endtask

  initial begin
    RST_N        = 1'b0;
    RST_FSM_FX   = 1'b0;
    Begin_FSM_FX = 1'b0;
    FX           = 32'h0;
    #1;
    check("reset result", RESULT, 32'h0);
    check("reset ack", {31'd0, ACK_FX}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    convert(32'h0001_0000, "one");
    convert(32'hFFFF_0000, "minus_one");
    convert(32'h0000_0000, "zero");
    convert(32'h8000_0000, "most_negative");
    convert(32'h0000_0001, "lsb");
    convert(32'h7FFF_FFFF, "most_positive");
    convert(32'h0100_0001, "tie_even");
    convert(32'h0100_0003, "tie_odd");
    convert(32'hFF00_0000, "neg_round");
    convert(32'h00FF_FFFF, "exact_24bit");

    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      convert(r, "random");
    end

    // Synchronous FSM reset in the middle of normalization.
    @(negedge CLK);
    FX           = 32'h0000_0001;
    Begin_FSM_FX = 1'b1;
    @(posedge CLK);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST_FSM_FX   = 1'b1;
    Begin_FSM_FX = 1'b0;
    @(posedge CLK);
    #1;
    check("fsm_rst ack", {31'd0, ACK_FX}, 32'd0);
    check("fsm_rst result", RESULT, last_exp);
    @(negedge CLK);
    RST_FSM_FX = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    check("fsm_rst idle ack", {31'd0, ACK_FX}, 32'd0);
    check("fsm_rst idle result", RESULT, last_exp);
    convert(32'h0001_0000, "after_fsm_rst");

    // Asynchronous reset in the middle of normalization.
    @(negedge CLK);
    FX           = 32'h0000_0001;
    Begin_FSM_FX = 1'b1;
    @(posedge CLK);
    repeat (5) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("async_rst result", RESULT, 32'h0);
    check("async_rst ack", {31'd0, ACK_FX}, 32'd0);
    @(negedge CLK);
    Begin_FSM_FX = 1'b0;
    RST_N        = 1'b1;
    convert(32'hFFFF_0000, "after_async_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
